// File: rtl/piano_pkg.sv
// Note codes and half-period constants shared by the note divider and the tone decoder.
package piano_pkg;

    localparam logic [2:0] NOTE_DO4 = 3'd0;
    localparam logic [2:0] NOTE_RE4 = 3'd1;
    localparam logic [2:0] NOTE_MI4 = 3'd2;
    localparam logic [2:0] NOTE_FA4 = 3'd3;
    localparam logic [2:0] NOTE_SOL4 = 3'd4;
    localparam logic [2:0] NOTE_LA4 = 3'd5;
    localparam logic [2:0] NOTE_SI4 = 3'd6;
    localparam logic [2:0] NOTE_DO5 = 3'd7;

    localparam int unsigned HP_DO4 = 191113;
    localparam int unsigned HP_RE4 = 170263;
    localparam int unsigned HP_MI4 = 151687;
    localparam int unsigned HP_FA4 = 143173;
    localparam int unsigned HP_SOL4 = 127553;
    localparam int unsigned HP_LA4 = 113637;
    localparam int unsigned HP_SI4 = 101239;
    localparam int unsigned HP_DO5 = 95557;

    // A measurement >= THR_x decodes to note x (or a lower note).
    localparam int unsigned THR_DO4 = (HP_DO4 + HP_RE4) / 2;
    localparam int unsigned THR_RE4 = (HP_RE4 + HP_MI4) / 2;
    localparam int unsigned THR_MI4 = (HP_MI4 + HP_FA4) / 2;
    localparam int unsigned THR_FA4 = (HP_FA4 + HP_SOL4) / 2;
    localparam int unsigned THR_SOL4 = (HP_SOL4 + HP_LA4) / 2;
    localparam int unsigned THR_LA4 = (HP_LA4 + HP_SI4) / 2;
    localparam int unsigned THR_SI4 = (HP_SI4 + HP_DO5) / 2;

    typedef enum logic [1:0] {
        LK_IDLE,
        LK_ARMED,
        LK_TRACK,
        LK_LOCKED
    } lock_state_e;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous level, followed by a registered
// any-edge pulse (one clk_in cycle per rising or falling transition).
module edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            sync_3     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync_1     <= async_in;
            sync_2     <= sync_1;
            sync_3     <= sync_2;
            edge_pulse <= sync_2 ^ sync_3;
        end
    end

endmodule

// File: rtl/tone_decoder.sv
// Measures the half-period of a square-wave tone and reports which of the
// eight scale notes Do4..Do5 is playing once it has been seen LOCK_CNT times.
module tone_decoder
    import piano_pkg::*;
#(
    parameter int CNT_W    = 18,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 4096,
    parameter int HP_SHIFT = 0
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             tone_in,
    output logic [2:0]       note,
    output logic             note_valid,
    output logic             note_strobe,
    output logic [CNT_W-1:0] half_period,
    output lock_state_e      state_dbg
);

    localparam int MW   = CNT_W + 1;
    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [MC_W-1:0]  LOCK_N  = MC_W'(LOCK_CNT);

    // HP_SHIFT scales every half-period constant down by 2^HP_SHIFT.
    localparam logic [MW-1:0] T_DO4  = MW'(THR_DO4 >> HP_SHIFT);
    localparam logic [MW-1:0] T_RE4  = MW'(THR_RE4 >> HP_SHIFT);
    localparam logic [MW-1:0] T_MI4  = MW'(THR_MI4 >> HP_SHIFT);
    localparam logic [MW-1:0] T_FA4  = MW'(THR_FA4 >> HP_SHIFT);
    localparam logic [MW-1:0] T_SOL4 = MW'(THR_SOL4 >> HP_SHIFT);
    localparam logic [MW-1:0] T_LA4  = MW'(THR_LA4 >> HP_SHIFT);
    localparam logic [MW-1:0] T_SI4  = MW'(THR_SI4 >> HP_SHIFT);
    localparam logic [MW-1:0] BAND_LO = MW'((HP_DO5 >> HP_SHIFT) - TOL);
    localparam logic [MW-1:0] BAND_HI = MW'((HP_DO4 >> HP_SHIFT) + TOL);

    logic             tone_edge;
    logic [CNT_W-1:0] cnt;
    logic [MW-1:0]    m;
    logic             timeout;

    logic             meas_vld;
    logic [MW-1:0]    m_q;
    logic             cls_vld;
    logic [2:0]       cls_q;
    logic [2:0]       cls_next;
    logic             oob_q;

    lock_state_e      state;
    logic [2:0]       cand;
    logic [MC_W-1:0]  match;
    logic [MC_W-1:0]  match_next;
    logic             set_q;
    logic             clr_q;
    logic [2:0]       pend_note;

    edge_sync u_edge_sync (
        .clk_in     (clk_in),
        .rst        (rst),
        .async_in   (tone_in),
        .edge_pulse (tone_edge)
    );

    assign m         = {1'b0, cnt} + MW'(1);
    assign timeout   = (cnt == CNT_MAX) && !tone_edge && (state != LK_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tone_edge) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // An edge while disarmed only arms; m = 2^CNT_W reads back as all-ones.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            meas_vld    <= 1'b0;
            m_q         <= '0;
            half_period <= '0;
        end else begin
            meas_vld <= tone_edge && (state != LK_IDLE);
            if (tone_edge && (state != LK_IDLE)) begin
                m_q         <= m;
                half_period <= m[CNT_W] ? CNT_MAX : m[CNT_W-1:0];
            end
        end
    end

    always_comb begin
        if (m_q >= T_DO4)       cls_next = NOTE_DO4;
        else if (m_q >= T_RE4)  cls_next = NOTE_RE4;
        else if (m_q >= T_MI4)  cls_next = NOTE_MI4;
        else if (m_q >= T_FA4)  cls_next = NOTE_FA4;
        else if (m_q >= T_SOL4) cls_next = NOTE_SOL4;
        else if (m_q >= T_LA4)  cls_next = NOTE_LA4;
        else if (m_q >= T_SI4)  cls_next = NOTE_SI4;
        else                    cls_next = NOTE_DO5;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cls_vld <= 1'b0;
            cls_q   <= NOTE_DO4;
            oob_q   <= 1'b0;
        end else begin
            cls_vld <= meas_vld;
            if (meas_vld) begin
                cls_q <= cls_next;
                oob_q <= (m_q < BAND_LO) || (m_q > BAND_HI);
            end
        end
    end

    always_comb begin
        match_next = MC_W'(1);
        if ((state != LK_ARMED) && (cls_q == cand)) begin
            match_next = (match == LOCK_N) ? LOCK_N : match + MC_W'(1);
        end
    end

    // note_valid is high while a locked note is on note; note_strobe is a
    // single-cycle pulse when note_valid rises or note changes while valid.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state       <= LK_IDLE;
            cand        <= NOTE_DO4;
            match       <= '0;
            set_q       <= 1'b0;
            clr_q       <= 1'b0;
            pend_note   <= NOTE_DO4;
            note        <= NOTE_DO4;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
        end else begin
            set_q <= 1'b0;
            clr_q <= 1'b0;
            if (timeout) begin
                state <= LK_IDLE;
                match <= '0;
                clr_q <= 1'b1;
            end else if (state == LK_IDLE) begin
                if (tone_edge) state <= LK_ARMED;
            end else if (cls_vld) begin
                if (oob_q) begin
                    state <= LK_ARMED;
                    match <= '0;
                    clr_q <= 1'b1;
                end else begin
                    cand  <= cls_q;
                    match <= match_next;
                    if (match_next == LOCK_N) begin
                        set_q     <= 1'b1;
                        pend_note <= cls_q;
                        state     <= LK_LOCKED;
                    end else if (state != LK_LOCKED) begin
                        state <= LK_TRACK;
                    end
                end
            end

            note_strobe <= 1'b0;
            if (set_q) begin
                note        <= pend_note;
                note_valid  <= 1'b1;
                note_strobe <= !note_valid || (note != pend_note);
            end else if (clr_q) begin
                note_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder, run in a reduced-scale configuration
// (HP_SHIFT=7: every half-period constant divided by 128, CNT_W=11, TOL=32).
module tb_tone_decoder;
    import piano_pkg::*;

    localparam int CNT_W    = 11;
    localparam int LOCK_CNT = 4;
    localparam int TOL      = 32;
    localparam int HP_SHIFT = 7;

    // Hand-scaled half-periods: floor(constant / 128).
    localparam int N_MI4   = 1185;  // 151687 -> Mi4, class 010
    localparam int N_DO5   = 746;   // 95557  -> Do5, class 111
    localparam int N_SOL4  = 996;   // 127553 -> Sol4, class 100
    localparam int N_B_HI  = 1411;  // 180688 -> exactly the Do4/Re4 threshold, class 000
    localparam int N_B_LO  = 1410;  // one below the threshold, class 001
    localparam int N_OOB   = 390;   // 50000  -> below 746-32
    localparam int N_QUIET = 2200;  // longer than the 2^11 saturation window

    logic             clk_in = 1'b0;
    logic             rst;
    logic             tone_in;
    logic [2:0]       note;
    logic             note_valid;
    logic             note_strobe;
    logic [CNT_W-1:0] half_period;
    lock_state_e      state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int since = 0;
    int strobes = 0;
    int s0;

    tone_decoder #(
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT),
        .TOL      (TOL),
        .HP_SHIFT (HP_SHIFT)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tone_in     (tone_in),
        .note        (note),
        .note_valid  (note_valid),
        .note_strobe (note_strobe),
        .half_period (half_period),
        .state_dbg   (state_dbg)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (note_strobe) strobes++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        since++;
    endtask

    // Toggle tone_in exactly n cycles after the previous toggle.
    task automatic tone_step(input int n);
        while (since < n) tick();
        #1 tone_in = ~tone_in;
        since = 0;
    endtask

    // Let a just-taken measurement reach the outputs, then sample off-edge.
    task automatic peek();
        repeat (10) tick();
        #2;
    endtask

    task automatic tone_run(input int n, input int count);
        for (int k = 0; k < count; k++) tone_step(n);
        peek();
    endtask

    initial begin
        rst     = 1'b1;
        tone_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #2;
        check_eq("rst_note", note, 0);
        check_eq("rst_valid", note_valid, 0);
        check_eq("rst_strobe", note_strobe, 0);
        check_eq("rst_half_period", half_period, 0);
        check_eq("rst_state", state_dbg, LK_IDLE);
        @(posedge clk_in);
        #1 rst = 1'b0;

        // Mi4: one arming edge plus three measurements is not yet a lock.
        s0 = strobes;
        tone_run(N_MI4, 4);
        check_eq("mi4_pre_valid", note_valid, 0);
        check_eq("mi4_pre_half_period", half_period, N_MI4);
        tone_run(N_MI4, 1);
        check_eq("mi4_note", note, 3'b010);
        check_eq("mi4_valid", note_valid, 1);
        check_eq("mi4_half_period", half_period, N_MI4);
        check_eq("mi4_strobes", strobes - s0, 1);

        // Switch to Do5: old note holds for three measurements.
        s0 = strobes;
        tone_run(N_DO5, 3);
        check_eq("do5_hold_valid", note_valid, 1);
        check_eq("do5_hold_note", note, 3'b010);
        check_eq("do5_hold_strobes", strobes - s0, 0);
        tone_run(N_DO5, 1);
        check_eq("do5_note", note, 3'b111);
        check_eq("do5_valid", note_valid, 1);
        check_eq("do5_half_period", half_period, N_DO5);
        check_eq("do5_strobes", strobes - s0, 1);

        // Threshold boundary: equal decodes to Do4, one below to Re4.
        s0 = strobes;
        tone_run(N_B_HI, 4);
        check_eq("bnd_hi_note", note, 3'b000);
        check_eq("bnd_hi_half_period", half_period, N_B_HI);
        tone_run(N_B_LO, 4);
        check_eq("bnd_lo_note", note, 3'b001);
        check_eq("bnd_lo_valid", note_valid, 1);
        check_eq("bnd_strobes", strobes - s0, 2);

        // Out-of-band measurement drops valid silently, note holds.
        s0 = strobes;
        tone_run(N_OOB, 1);
        check_eq("oob_valid", note_valid, 0);
        check_eq("oob_note", note, 3'b001);
        check_eq("oob_half_period", half_period, N_OOB);
        check_eq("oob_strobes", strobes - s0, 0);
        check_eq("oob_state", state_dbg, LK_ARMED);

        // Relock on Do5 straight from ARMED (no arming edge needed).
        s0 = strobes;
        tone_run(N_DO5, 4);
        check_eq("relock_note", note, 3'b111);
        check_eq("relock_valid", note_valid, 1);
        check_eq("relock_strobes", strobes - s0, 1);

        // Silence: timeout drops valid and disarms.
        s0 = strobes;
        repeat (N_QUIET) tick();
        #2;
        check_eq("quiet_valid", note_valid, 0);
        check_eq("quiet_note", note, 3'b111);
        check_eq("quiet_state", state_dbg, LK_IDLE);
        check_eq("quiet_strobes", strobes - s0, 0);

        // After timeout the first edge only arms: five Sol4 edges to lock.
        tone_run(N_SOL4, 4);
        check_eq("sol4_pre_valid", note_valid, 0);
        tone_run(N_SOL4, 1);
        check_eq("sol4_note", note, 3'b100);
        check_eq("sol4_valid", note_valid, 1);
        check_eq("sol4_half_period", half_period, N_SOL4);
        check_eq("sol4_strobes", strobes - s0, 1);

        // Asynchronous reset mid-count while locked.
        repeat (300) tick();
        #1 rst = 1'b1;
        #1;
        check_eq("arst_note", note, 0);
        check_eq("arst_valid", note_valid, 0);
        check_eq("arst_half_period", half_period, 0);
        check_eq("arst_strobe", note_strobe, 0);
        repeat (3) tick();
        #1 rst = 1'b0;
        s0 = strobes;
        tone_run(N_SOL4, 4);
        check_eq("post_rst_valid", note_valid, 0);
        check_eq("post_rst_strobes", strobes - s0, 0);
        tone_run(N_SOL4, 1);
        check_eq("post_rst_note", note, 3'b100);
        check_eq("post_rst_lock", note_valid, 1);
        check_eq("post_rst_lock_strobes", strobes - s0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tone_decoder.md
Name: tone_decoder

Overview:
- Receives a square-wave tone of the kind produced by the team's note clock divider.
- Measures the tone's half-period in clk_in cycles and decides which of the 8 scale notes Do4..Do5 is being played.
- Reports the note as the 3-bit code used by the divider's scaler input, with valid/strobe qualifiers.
- Sits on the capture side of the piano path and is used for loopback self-test and note display.

Parameters:
- CNT_W, 18: width of the half-period counter and measurement.
- LOCK_CNT, 4: consecutive same-note measurements required before the note is reported.
- TOL, 4096: out-of-band margin in cycles below Do5 and above Do4.

Ports:
- clk_in  input  1  system clock, same domain as the note divider.
- rst  input  1  asynchronous, active-high reset.
- tone_in  input  1  asynchronous square-wave tone.
- note  output  3  decoded note code: 000=Do4 through 111=Do5.
- note_valid  output  1  high while a locked note is reported.
- note_strobe  output  1  one-cycle pulse when note_valid rises or note changes.
- half_period  output  CNT_W  last measured half-period in cycles.

Behaviour:
- Interface: one clock, clk_in. Reset rst is asynchronous and active-high.
- Reset values:
  - note=000, note_valid=0, note_strobe=0, half_period=0.
  - Internal counters cleared; measurement disarmed.
- Input synchronisation:
  - tone_in passes through a 2-flop synchronizer, then a registered edge detector.
  - Any edge counts, rising or falling.
- Counter (cnt):
  - Cleared to 0 in the edge cycle; otherwise increments, saturating at 2^CNT_W-1.
  - Measured half-period m = cnt+1 at the edge. A divider toggling every N cycles yields m = N exactly.
- Arming:
  - The first edge after reset or timeout only arms the block; no measurement is taken.
  - On each later edge, half_period <= m in the next cycle.
- Classification (registered one cycle after half_period updates). Checked in order, using >=:
  - m >= 180688 → 000
  - m >= 160975 → 001
  - m >= 147430 → 010
  - m >= 135363 → 011
  - m >= 120595 → 100
  - m >= 107438 → 101
  - m >= 98398 → 110
  - otherwise → 111
- Out-of-band: m < 95557-TOL or m > 191113+TOL.
- Lock state machine:
  - States: IDLE (disarmed), ARMED (no candidate), TRACK (candidate and match count), LOCKED.
  - In-band class equal to the candidate: match count increments, saturating at LOCK_CNT.
  - On reaching LOCK_CNT: note <= candidate, note_valid <= 1, enter LOCKED.
  - In-band class different from the candidate: candidate <= class, match count <= 1.
  - In LOCKED, a different class does not drop note_valid. The old note stays reported until the new candidate reaches LOCK_CNT, then note switches.
  - Out-of-band measurement: note_valid <= 0, match count <= 0, go to ARMED. note holds its last value.
- Timeout: cnt saturates (no edge for 2^CNT_W-1 cycles, silence).
  - note_valid <= 0, go to IDLE; the next edge only re-arms.
- note_strobe:
  - Asserted for exactly one cycle when note_valid goes 0→1, or when note changes while valid.
  - Never asserted on the valid→0 transition.
- Latency: lock is declared in the cycle after the LOCK_CNTth matching measurement is classified; note_valid/note update and note_strobe pulse one cycle later, 4 cycles after the edge is detected.
- Simultaneous events: an edge in the same cycle as saturation is treated as an edge (measurement m = 2^CNT_W, out-of-band), not a timeout.
- Reset mid-measurement: all state is discarded immediately, with no strobe.

Decomposition:
- Shared package piano_pkg:
  - Note code constants NOTE_DO4..NOTE_DO5.
  - Half-period constants 191113, 170263, 151687, 143173, 127553, 113637, 101239, 95557.
  - The seven midpoint thresholds.
  - The same constants feed the divider.
- Sub-module: edge_sync. Holds the 2-flop synchronizer plus edge pulse, reusable for key inputs.
- Classifier stays inline as a priority compare.

Test Plan:
- Divider model with N=151687 (Mi4) on tone_in after reset.
  - First edge arms; after 4 measured half-periods, note=010 and note_valid=1.
  - note_strobe pulses exactly once.
  - half_period reads 151687.
- Locked on Mi4 (010), switch to N=95557 (Do5).
  - note_valid stays 1; note stays 010 for 3 measurements.
  - Then note=111 with one strobe.
- Boundary: half-period exactly 180688 → class 000; half-period 180687 → class 001.
- Out-of-band: half-period 50000 after lock → note_valid=0 within one measurement, no strobe, note holds last value.
- Hold tone_in constant 262143+ cycles while locked → note_valid=0.
  - First new edge gives no measurement; 5 edges of Sol4 (N=127553) then lock note=100.
- Assert rst mid-count while locked → all outputs 0 asynchronously; no strobe after release until relock.
